// File: rtl/trigger_capture.sv
// Level/slope triggered frame capture with pre-trigger history into a circular buffer,
// frozen for random-access readout by the waveform renderer.
module trigger_capture #(
    parameter int unsigned DEPTH   = 640,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned PRE     = 320,
    parameter int unsigned AUTO_TO = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [13:0]       DAC_in,
    input  logic              sample_en,
    input  logic [13:0]       trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [13:0]       rd_data,
    output logic              frame_valid,
    output logic              triggered,
    output logic              busy
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PW     = ADDR_W + 1;
    localparam int unsigned POST_N = DEPTH - PRE - 1;
    localparam int unsigned PRE_W  = $clog2(PRE + 1);
    localparam int unsigned POST_W = $clog2(POST_N + 1);
    localparam int unsigned TO_W   = $clog2(AUTO_TO + 1);

    localparam logic [1:0] M_AUTO   = 2'b00;
    localparam logic [1:0] M_NORMAL = 2'b01;
    localparam logic [1:0] M_SINGLE = 2'b10;
    localparam logic [1:0] M_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_HOLD
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_trig_ptr, w_trig_ptr_nxt;
    logic [13:0]         r_prev;
    logic [PRE_W-1:0]    r_pre_cnt, w_pre_cnt_nxt;
    logic [POST_W-1:0]   r_post_cnt, w_post_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
    logic                r_triggered, w_triggered_nxt;
    logic                r_busy;
    logic                r_frame_valid;
    logic [13:0]         r_rd_data;
    logic [13:0]         r_mem [DEPTH];

    logic                w_capturing;
    logic                w_accept;
    logic                w_rise, w_fall, w_edge;
    logic [PW-1:0]       w_base_sum, w_base, w_rd_sum, w_rd_phys;
    logic                w_rd_oob;

    assign w_capturing = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_accept    = w_capturing && sample_en;

    assign w_rise = (r_prev < trig_level) && (DAC_in >= trig_level);
    assign w_fall = (r_prev > trig_level) && (DAC_in <= trig_level);
    assign w_edge = trig_slope ? w_fall : w_rise;

    // Next-state, counters and trigger pointer
    always_comb begin
        w_state_nxt     = r_state;
        w_pre_cnt_nxt   = r_pre_cnt;
        w_post_cnt_nxt  = r_post_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_trig_ptr_nxt  = r_trig_ptr;
        w_triggered_nxt = r_triggered;
        case (r_state)
            S_IDLE: begin
                if ((trig_mode == M_AUTO) || (trig_mode == M_NORMAL) ||
                    ((trig_mode == M_SINGLE) && arm)) begin
                    w_state_nxt    = S_PRETRIG;
                    w_pre_cnt_nxt  = '0;
                    w_to_cnt_nxt   = '0;
                    w_post_cnt_nxt = '0;
                end
            end
            S_PRETRIG: begin
                if (trig_mode == M_STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (sample_en) begin
                    w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
                    if (r_pre_cnt == PRE_W'(PRE - 1)) begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (trig_mode == M_STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (sample_en) begin
                    if (w_edge) begin
                        w_trig_ptr_nxt  = r_wr_ptr;
                        w_triggered_nxt = 1'b1;
                        w_post_cnt_nxt  = '0;
                        w_state_nxt     = S_POST;
                    end else if (trig_mode == M_AUTO) begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                        // Timeout: current sample becomes the (untriggered) frame anchor
                        if (r_to_cnt == TO_W'(AUTO_TO - 1)) begin
                            w_trig_ptr_nxt = r_wr_ptr;
                            w_post_cnt_nxt = '0;
                            w_state_nxt    = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (sample_en) begin
                    w_post_cnt_nxt = r_post_cnt + POST_W'(1);
                    if (r_post_cnt == POST_W'(POST_N - 1)) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    w_state_nxt     = S_IDLE;
                    w_triggered_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_triggered_nxt = 1'b0;
            end
        endcase
        if (w_state_nxt == S_IDLE) begin
            w_triggered_nxt = 1'b0;
        end
    end

    // State, pointers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_trig_ptr    <= '0;
            r_prev        <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_to_cnt      <= '0;
            r_triggered   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_trig_ptr    <= w_trig_ptr_nxt;
            r_pre_cnt     <= w_pre_cnt_nxt;
            r_post_cnt    <= w_post_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_triggered   <= w_triggered_nxt;
            r_busy        <= (w_state_nxt == S_PRETRIG) || (w_state_nxt == S_ARMED) ||
                             (w_state_nxt == S_POST);
            r_frame_valid <= (w_state_nxt == S_HOLD);
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);
                r_prev   <= DAC_in;
            end
        end
    end

    // Sample buffer; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[IDX_W'(r_wr_ptr)] <= DAC_in;
        end
    end

    // Logical-to-physical mapping, two bounded subtracts keep sums within ADDR_W+1 bits
    assign w_base_sum = PW'(r_trig_ptr) + PW'(DEPTH - PRE);
    assign w_base     = (w_base_sum >= PW'(DEPTH)) ? w_base_sum - PW'(DEPTH) : w_base_sum;
    assign w_rd_sum   = w_base + PW'(rd_addr);
    assign w_rd_phys  = (w_rd_sum >= PW'(DEPTH)) ? w_rd_sum - PW'(DEPTH) : w_rd_sum;
    assign w_rd_oob   = (PW'(rd_addr) >= PW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_oob ? 14'd0 : r_mem[IDX_W'(w_rd_phys)];
        end
    end

    assign rd_data     = r_rd_data;
    assign frame_valid = r_frame_valid;
    assign triggered   = r_triggered;
    assign busy        = r_busy;

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: expected frames come from a stream-level trigger model.
module tb_trigger_capture;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 5;
    localparam int PRE     = 4;
    localparam int AUTO_TO = 20;
    localparam int SLEN    = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [13:0]       DAC_in = '0;
    logic              sample_en = 1'b0;
    logic [13:0]       trig_level = 14'd4096;
    logic              trig_slope = 1'b0;
    logic [1:0]        trig_mode = 2'b01;
    logic              arm = 1'b0;
    logic              frame_ack = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [13:0]       rd_data;
    logic              frame_valid;
    logic              triggered;
    logic              busy;

    int                n_chk = 0;
    int                n_bad = 0;
    logic [13:0]       exp_q[$];
    logic [13:0]       stim [SLEN];

    trigger_capture #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .PRE     (PRE),
        .AUTO_TO (AUTO_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DAC_in      (DAC_in),
        .sample_en   (sample_en),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .trig_mode   (trig_mode),
        .arm         (arm),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .triggered   (triggered),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Index of the frame anchor sample in stim, and whether it is a real edge
    task automatic find_trig(input int len, input logic [1:0] mode, input logic slope,
                             input logic [13:0] lvl, output int t, output logic hit);
        logic [13:0] p, c;
        t   = -1;
        hit = 1'b0;
        for (int i = PRE; i < len; i++) begin
            p = stim[i-1];
            c = stim[i];
            if ((!slope && p < lvl && c >= lvl) || (slope && p > lvl && c <= lvl)) begin
                t   = i;
                hit = 1'b1;
                return;
            end
            if (mode == 2'b00 && (i - PRE + 1) == AUTO_TO) begin
                t = i;
                return;
            end
        end
    endtask

    task automatic wait_busy(input string tag);
        int cyc = 0;
        while (busy !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic capture(input string tag, input int len, input int gap_at);
        int   t, sent, cyc, gap_left;
        logic hit;
        find_trig(len, trig_mode, trig_slope, trig_level, t, hit);
        if (t < 0 || t + DEPTH - PRE > len) begin
            $display("FAIL %s: stimulus holds no complete frame", tag);
            $fatal(1);
        end
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(stim[t - PRE + k]);
        wait_busy(tag);
        sent     = 0;
        cyc      = 0;
        gap_left = 5;
        while (frame_valid !== 1'b1 && cyc < 300) begin
            if (sent == gap_at && gap_left > 0) begin
                sample_en = 1'b0;
                gap_left--;
            end else if (sent < len) begin
                DAC_in    = stim[sent];
                sample_en = 1'b1;
                sent++;
            end else begin
                sample_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        sample_en = 1'b0;
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'd1);
        chk({tag, " samples"}, 32'(sent), 32'(t + DEPTH - PRE));
        chk({tag, " triggered"}, 32'(triggered), 32'(hit));
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = ADDR_W'(a);
            @(negedge clk);
            chk($sformatf("%s rd%0d", tag, a), 32'(rd_data), 32'(exp_q.pop_front()));
        end
        rd_addr = ADDR_W'(DEPTH);
        @(negedge clk);
        chk({tag, " rd_oob"}, 32'(rd_data), 32'd0);
        chk({tag, " hold busy"}, 32'(busy), 32'd0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk({tag, " fv after ack"}, 32'(frame_valid), 32'd0);
        chk({tag, " trig after ack"}, 32'(triggered), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_valid", 32'(frame_valid), 32'd0);
        chk("rst triggered", 32'(triggered), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Rising ramp through midscale
        for (int i = 0; i < SLEN; i++) stim[i] = 14'(4000 + 10 * i);
        capture("ramp", 22, -1);

        // Falling slope on a square wave
        trig_slope = 1'b1;
        for (int i = 0; i < SLEN; i++) stim[i] = ((i / 4) % 2 == 0) ? 14'd6000 : 14'd2000;
        capture("square", 40, -1);

        // Auto mode with no edge: forced frame
        trig_slope = 1'b0;
        trig_mode  = 2'b00;
        for (int i = 0; i < SLEN; i++) stim[i] = 14'd4096;
        capture("auto", 50, -1);

        // Single shot needs arm, and does not re-arm on its own
        trig_mode = 2'b11;
        repeat (3) @(negedge clk);
        chk("stop busy", 32'(busy), 32'd0);
        trig_mode = 2'b10;
        repeat (5) @(negedge clk);
        chk("single unarmed busy", 32'(busy), 32'd0);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("single armed busy", 32'(busy), 32'd1);
        for (int i = 0; i < SLEN; i++) stim[i] = 14'(3000 + 50 * i);
        capture("single", 40, -1);
        repeat (5) @(negedge clk);
        chk("single no rearm", 32'(busy), 32'd0);

        // Reset in the middle of POST
        trig_mode = 2'b01;
        rd_addr   = '0;
        for (int i = 0; i < SLEN; i++) stim[i] = 14'(4000 + 10 * i);
        wait_busy("pre-reset");
        for (int k = 0; k < 13; k++) begin
            DAC_in    = stim[k];
            sample_en = 1'b1;
            @(negedge clk);
        end
        sample_en = 1'b0;
        chk("mid-post triggered", 32'(triggered), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst triggered", 32'(triggered), 32'd0);
        chk("async rst frame_valid", 32'(frame_valid), 32'd0);
        chk("async rst rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pre-trigger edge ignored, real edge at 9, gap in POST, frame wraps 15->0
        for (int i = 0; i < SLEN; i++) begin
            if (i == 2 || i == 3 || i >= 9) stim[i] = 14'(8000 + i);
            else                             stim[i] = 14'(1000 + i);
        end
        capture("wrap", 30, 12);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
